cpu_bus_cycle_ctrl: RTL and testbench

- Sequences every 68000 bus cycle after address decode.
- Takes the active-low chip selects from the decoder and resolves a single region per cycle.
- Internal regions: inserts a configurable number of wait states, then asserts DTACK.
- External (SDRAM-backed) regions: issues a request/ack handshake to the memory arbiter and asserts DTACK on completion.
- Sits between the CPU core, the address decoder and the SDRAM/BRAM request fabric.

---
 rtl/cpu_bus_cycle_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_cpu_bus_cycle_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module : cpu_bus_cycle_ctrl
// Desc   : 68000 bus-cycle sequencer. Internal regions get wait states then
//          DTACK; external regions use a req/ack handshake to the memory
//          fabric. Optional bus-error timeout: define CPU_BERR_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module cpu_bus_cycle_ctrl #(
    parameter int NUM_SEL = 16,
    parameter int WAIT_W  = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_ce,
    input  logic                      cpu_as_n,
    input  logic [1:0]                cpu_ds_n,
    input  logic [NUM_SEL-1:0]        sel_n,
    input  logic [NUM_SEL-1:0]        ext_mask,
    input  logic [NUM_SEL*WAIT_W-1:0] wait_cfg,
    output logic                      ext_req,
    output logic [NUM_SEL-1:0]        ext_sel,
    input  logic                      ext_ack,
    output logic                      cpu_dtack_n,
    output logic                      cpu_berr_n,
    output logic                      busy
);

    localparam int c_IDX_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_WAIT  = 3'd1;
    localparam logic [2:0] c_EXT   = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;
`ifdef CPU_BERR_TIMEOUT_EN
    localparam logic [2:0] c_BERR  = 3'd5;
    localparam int         c_TMO_W = $clog2(TIMEOUT + 1);
`endif

    logic [2:0]         r_state,    w_state_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt, w_wait_nxt;
    logic               r_ext_req,  w_req_nxt;
    logic [NUM_SEL-1:0] r_ext_sel,  w_sel_nxt;
    logic               r_dtack_n;

    logic               w_start;
    logic               w_hit;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_is_ext;
    logic [WAIT_W-1:0]  w_wait_sel;
    logic [NUM_SEL-1:0] w_onehot;

`ifdef CPU_BERR_TIMEOUT_EN
    logic [c_TMO_W-1:0] r_tmo, w_tmo_nxt;
    logic               r_berr_n;
`endif

    assign w_start = cpu_ce && !cpu_as_n && (cpu_ds_n != 2'b11);

    // Scan high-to-low so the lowest asserted select is the last one written.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NUM_SEL - 1; i >= 0; i--) begin
            if (!sel_n[i]) begin
                w_hit = 1'b1;
                w_idx = c_IDX_W'(i);
            end
        end
    end

    // No select asserted behaves as an internal zero-wait region (open bus).
    assign w_is_ext   = w_hit && ext_mask[w_idx];
    assign w_wait_sel = w_hit ? wait_cfg[w_idx*WAIT_W +: WAIT_W] : '0;
    assign w_onehot   = NUM_SEL'(1) << w_idx;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_sel_nxt   = r_ext_sel;
        w_req_nxt   = 1'b0;
`ifdef CPU_BERR_TIMEOUT_EN
        w_tmo_nxt   = r_tmo;
`endif
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    if (w_is_ext) begin
                        w_state_nxt = c_EXT;
                        w_req_nxt   = 1'b1;
                        w_sel_nxt   = w_onehot;
`ifdef CPU_BERR_TIMEOUT_EN
                        w_tmo_nxt   = '0;
`endif
                    end else if (w_wait_sel == '0) begin
                        w_state_nxt = c_DONE;
                    end else begin
                        w_state_nxt = c_WAIT;
                        w_wait_nxt  = w_wait_sel;
                    end
                end
            end
            c_WAIT: begin
                if (cpu_as_n) begin
                    w_state_nxt = c_IDLE;
                    w_wait_nxt  = '0;
                end else if (cpu_ce) begin
                    if (r_wait_cnt == WAIT_W'(1)) begin
                        w_state_nxt = c_DONE;
                        w_wait_nxt  = '0;
                    end else begin
                        w_wait_nxt  = r_wait_cnt - WAIT_W'(1);
                    end
                end
            end
            c_EXT: begin
                // An ack coincident with our own request pulse is stale.
                if (ext_ack && !r_ext_req) begin
                    w_state_nxt = c_DONE;
                    w_sel_nxt   = '0;
                end else if (cpu_as_n) begin
                    w_state_nxt = c_DRAIN;
`ifdef CPU_BERR_TIMEOUT_EN
                end else if (r_tmo == c_TMO_W'(TIMEOUT - 1)) begin
                    w_state_nxt = c_BERR;
                end else begin
                    w_tmo_nxt   = r_tmo + c_TMO_W'(1);
`endif
                end
            end
            c_DRAIN: begin
                if (ext_ack) begin
                    w_state_nxt = c_IDLE;
                    w_sel_nxt   = '0;
                end
            end
            c_DONE: begin
                if (cpu_as_n) begin
                    w_state_nxt = c_IDLE;
                end
            end
`ifdef CPU_BERR_TIMEOUT_EN
            c_BERR: begin
                // A non-zero ext_sel marks the external access still in flight.
                if (ext_ack) begin
                    w_sel_nxt = '0;
                end
                if (cpu_as_n) begin
                    w_state_nxt = ((r_ext_sel != '0) && !ext_ack) ? c_DRAIN : c_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = c_IDLE;
                w_sel_nxt   = '0;
                w_wait_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_wait_cnt <= '0;
            r_ext_req  <= 1'b0;
            r_ext_sel  <= '0;
            r_dtack_n  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_ext_req  <= w_req_nxt;
            r_ext_sel  <= w_sel_nxt;
            r_dtack_n  <= (w_state_nxt != c_DONE);
        end
    end

`ifdef CPU_BERR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo    <= '0;
            r_berr_n <= 1'b1;
        end else begin
            r_tmo    <= w_tmo_nxt;
            r_berr_n <= (w_state_nxt != c_BERR);
        end
    end

    assign cpu_berr_n = r_berr_n;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign cpu_berr_n       = 1'b1;
`endif

    assign ext_req     = r_ext_req;
    assign ext_sel     = r_ext_sel;
    assign cpu_dtack_n = r_dtack_n;
    assign busy        = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_bus_cycle_ctrl
// Desc   : Directed self-checking bench for cpu_bus_cycle_ctrl; expected DTACK
//          cycles are queued at stimulus time and checked when DTACK appears.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cpu_bus_cycle_ctrl;

    localparam int NUM_SEL = 16;
    localparam int WAIT_W  = 4;
    localparam int TIMEOUT = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      cpu_ce;
    logic                      cpu_as_n;
    logic [1:0]                cpu_ds_n;
    logic [NUM_SEL-1:0]        sel_n;
    logic [NUM_SEL-1:0]        ext_mask;
    logic [NUM_SEL*WAIT_W-1:0] wait_cfg;
    logic                      ext_req;
    logic [NUM_SEL-1:0]        ext_sel;
    logic                      ext_ack;
    logic                      cpu_dtack_n;
    logic                      cpu_berr_n;
    logic                      busy;

    typedef struct {
        string tag;
        int    due;
    } exp_t;

    exp_t sb_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;
    bit   ce_div2 = 1'b0;
    int   req_cnt  = 0;
    int   berr_cnt = 0;
    int   c0;
    int   r0;

    cpu_bus_cycle_ctrl #(
        .NUM_SEL (NUM_SEL),
        .WAIT_W  (WAIT_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_ce      (cpu_ce),
        .cpu_as_n    (cpu_as_n),
        .cpu_ds_n    (cpu_ds_n),
        .sel_n       (sel_n),
        .ext_mask    (ext_mask),
        .wait_cfg    (wait_cfg),
        .ext_req     (ext_req),
        .ext_sel     (ext_sel),
        .ext_ack     (ext_ack),
        .cpu_dtack_n (cpu_dtack_n),
        .cpu_berr_n  (cpu_berr_n),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Counts clocks with ext_req high and with BERR asserted.
    always @(posedge clk) begin
        #1;
        if (ext_req)     req_cnt++;
        if (!cpu_berr_n) berr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; returns at the falling edge where inputs are driven and outputs sampled.
    task automatic tick();
        @(negedge clk);
        cyc++;
        cpu_ce = ce_div2 ? cyc[0] : 1'b1;
    endtask

    // due = number of ticks after this drive point at which DTACK must first be seen low.
    task automatic start_cycle(input logic [15:0] sel, input logic [1:0] ds,
                               input int lat, input string tag);
        sel_n    = sel;
        cpu_as_n = 1'b0;
        cpu_ds_n = ds;
        if (lat > 0) sb_q.push_back('{tag: tag, due: cyc + lat});
    endtask

    task automatic wait_dtack(input int max_cyc);
        exp_t e;
        for (int k = 0; k < max_cyc && cpu_dtack_n; k++) tick();
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_underflow: observed=empty expected=entry");
        end else begin
            e = sb_q.pop_front();
            check({e.tag, "_dtack"}, {31'd0, cpu_dtack_n}, 32'd0);
            check({e.tag, "_cycle"}, cyc, e.due);
        end
    endtask

    task automatic release_bus(input string tag);
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        tick();
        check({tag, "_rel_dtack"}, {31'd0, cpu_dtack_n}, 32'd1);
        check({tag, "_rel_busy"},  {31'd0, busy},        32'd0);
    endtask

    task automatic wait_ce_high();
        for (int k = 0; k < 4 && !cpu_ce; k++) tick();
    endtask

    initial begin
        reset    = 1'b1;
        cpu_ce   = 1'b1;
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        sel_n    = '1;
        ext_ack  = 1'b0;
        ext_mask = 16'h0002;
        wait_cfg = '0;
        wait_cfg[5*WAIT_W +: WAIT_W] = 4'd4;
        wait_cfg[2*WAIT_W +: WAIT_W] = 4'd2;
        repeat (3) tick();
        check("rst_dtack", {31'd0, cpu_dtack_n}, 32'd1);
        check("rst_berr",  {31'd0, cpu_berr_n},  32'd1);
        check("rst_req",   {31'd0, ext_req},     32'd0);
        check("rst_sel",   ext_sel,              32'd0);
        check("rst_busy",  {31'd0, busy},        32'd0);
        reset = 1'b0;
        tick();

        // Internal region 3, zero waits: DTACK on the start edge itself.
        r0 = req_cnt;
        start_cycle(16'hFFF7, 2'b00, 1, "t1_zero_wait");
        wait_dtack(10);
        release_bus("t1");
        check("t1_no_req", req_cnt - r0, 32'd0);

        // Region 5, 4 waits, cpu_ce every 2nd clk: start edge + 8 clocks.
        ce_div2 = 1'b1;
        tick();
        wait_ce_high();
        start_cycle(16'hFFDF, 2'b01, 9, "t2_wait4");
        repeat (3) tick();
        cpu_ds_n = 2'b11;
        wait_dtack(20);
        release_bus("t2");

        // Same region, AS withdrawn after two cpu_ce pulses.
        tick();
        wait_ce_high();
        start_cycle(16'hFFDF, 2'b00, 0, "t2_abort");
        c0 = cyc;
        tick();
        check("t2ab_busy_start", {31'd0, busy}, 32'd1);
        while (cyc < c0 + 5) tick();
        check("t2ab_dtack_wait", {31'd0, cpu_dtack_n}, 32'd1);
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        tick();
        check("t2ab_busy_drop", {31'd0, busy},        32'd0);
        check("t2ab_no_dtack",  {31'd0, cpu_dtack_n}, 32'd1);
        repeat (3) tick();
        check("t2ab_no_dtack2", {31'd0, cpu_dtack_n}, 32'd1);
        ce_div2 = 1'b0;
        tick();

        // External region 1: coincident ack ignored, real ack 6 clocks after req.
        r0 = req_cnt;
        start_cycle(16'hFFFD, 2'b10, 0, "t3_ext");
        c0 = cyc;
        tick();
        check("t3_req",     {31'd0, ext_req}, 32'd1);
        check("t3_sel",     ext_sel,          32'h0002);
        ext_ack = 1'b1;
        tick();
        ext_ack = 1'b0;
        check("t3_req_once",     {31'd0, ext_req},     32'd0);
        check("t3_early_ack_busy", {31'd0, busy},      32'd1);
        check("t3_early_ack_dtk",  {31'd0, cpu_dtack_n}, 32'd1);
        check("t3_sel_held",     ext_sel,              32'h0002);
        while (cyc < c0 + 6) tick();
        ext_ack = 1'b1;
        sb_q.push_back('{tag: "t3_ack", due: cyc + 1});
        tick();
        ext_ack = 1'b0;
        wait_dtack(5);
        check("t3_sel_clr",  ext_sel,        32'd0);
        check("t3_req_cnt",  req_cnt - r0,   32'd1);
        release_bus("t3");

        // Lowest select wins: region 2 (2 waits) over region 3 (0 waits).
        start_cycle(16'hFFF3, 2'b00, 3, "t4_prio");
        wait_dtack(10);
        release_bus("t4a");

        // No select asserted: open-bus zero-wait DTACK.
        r0 = req_cnt;
        start_cycle(16'hFFFF, 2'b00, 1, "t4_open");
        wait_dtack(10);
        release_bus("t4b");
        check("t4b_no_req", req_cnt - r0, 32'd0);

        // External access abandoned by the CPU: DRAIN, then a held-off new cycle.
        start_cycle(16'hFFFD, 2'b00, 0, "t5_drain");
        tick();
        tick();
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        tick();
        check("t5_drain_busy",  {31'd0, busy},        32'd1);
        check("t5_drain_dtack", {31'd0, cpu_dtack_n}, 32'd1);
        r0 = req_cnt;
        start_cycle(16'hFFF7, 2'b00, 0, "t5_new");
        repeat (2) tick();
        check("t5_held_busy",  {31'd0, busy},        32'd1);
        check("t5_held_dtack", {31'd0, cpu_dtack_n}, 32'd1);
        check("t5_held_sel",   ext_sel,              32'h0002);
        ext_ack = 1'b1;
        sb_q.push_back('{tag: "t5_restart", due: cyc + 2});
        tick();
        ext_ack = 1'b0;
        check("t5_idle_after_ack", {31'd0, busy}, 32'd0);
        check("t5_sel_clr",        ext_sel,       32'd0);
        wait_dtack(5);
        check("t5_no_new_req", req_cnt - r0, 32'd0);
        release_bus("t5");

`ifdef CPU_BERR_TIMEOUT_EN
        // No ack: BERR after TIMEOUT clocks in EXT, then drain the late ack.
        start_cycle(16'hFFFD, 2'b00, 0, "t6_tmo");
        c0 = cyc;
        while (cyc < c0 + TIMEOUT) tick();
        check("t6_berr_pre",  {31'd0, cpu_berr_n},  32'd1);
        tick();
        check("t6_berr",      {31'd0, cpu_berr_n},  32'd0);
        check("t6_berr_dtk",  {31'd0, cpu_dtack_n}, 32'd1);
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        tick();
        check("t6_berr_rel",  {31'd0, cpu_berr_n},  32'd1);
        check("t6_drain",     {31'd0, busy},        32'd1);
        ext_ack = 1'b1;
        tick();
        ext_ack = 1'b0;
        check("t6_idle",      {31'd0, busy},        32'd0);
        check("t6_sel_clr",   ext_sel,              32'd0);
`else
        check("t6_berr_never", berr_cnt, 32'd0);
`endif

        // Reset in EXT abandons the access; a later stray ack is ignored.
        start_cycle(16'hFFFD, 2'b00, 0, "t7_rst");
        tick();
        tick();
        reset    = 1'b1;
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        tick();
        reset = 1'b0;
        check("t7_rst_busy",  {31'd0, busy},        32'd0);
        check("t7_rst_sel",   ext_sel,              32'd0);
        check("t7_rst_req",   {31'd0, ext_req},     32'd0);
        check("t7_rst_dtack", {31'd0, cpu_dtack_n}, 32'd1);
        check("t7_rst_berr",  {31'd0, cpu_berr_n},  32'd1);
        ext_ack = 1'b1;
        tick();
        ext_ack = 1'b0;
        tick();
        check("t7_stray_busy",  {31'd0, busy},        32'd0);
        check("t7_stray_dtack", {31'd0, cpu_dtack_n}, 32'd1);

        check("sb_left", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
